// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin sharing of one OBI subordinate port between NumMgr managers.
// Define OBI_RR_ARBITER_UNEXP_RSP_EN to flag (sticky) and drop rvalids that arrive with nothing outstanding.
package obi_rr_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_a_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_t;
  typedef struct packed {
    logic   req;
    obi_a_t a;
    logic   rready;
  } sbr_obi_req_t;
  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } sbr_obi_rsp_t;
endpackage

module obi_rr_arbiter
  import obi_rr_arbiter_pkg::*;
#(
  parameter int NumMgr   = 2,
  parameter int MaxTrans = 2,
  parameter int IdxW     = NumMgr > 1 ? $clog2(NumMgr) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t mgr_req_i [NumMgr],
  output sbr_obi_rsp_t mgr_rsp_o [NumMgr],
  output sbr_obi_req_t sbr_req_o,
  input  sbr_obi_rsp_t sbr_rsp_i,
  output logic         busy_o,
  output logic         unexp_rsp_o
);
  localparam int CntW = $clog2(MaxTrans + 1);
  localparam int PtrW = MaxTrans > 1 ? $clog2(MaxTrans) : 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_next;
  logic [IdxW-1:0] ptr, lock_idx, sel, idx, head;
  logic [IdxW-1:0] fifo [MaxTrans];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic any_req, full, accept, pop;
  function automatic logic [IdxW-1:0] wrap_mgr(input int v);
    return IdxW'(v >= NumMgr ? v - NumMgr : v);
  endfunction
  function automatic logic [PtrW-1:0] next_slot(input logic [PtrW-1:0] p);
    return p == PtrW'(MaxTrans - 1) ? '0 : p + 1'b1;
  endfunction
  assign full   = count == CntW'(MaxTrans);
  assign head   = fifo[rd_ptr];
  assign busy_o = count != '0;
  // Scan downwards so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    sel     = ptr;
    any_req = 1'b0;
    for (int i = NumMgr - 1; i >= 0; i--)
      if (mgr_req_i[wrap_mgr(int'(ptr) + i)].req) begin
        sel     = wrap_mgr(int'(ptr) + i);
        any_req = 1'b1;
      end
  end
  // LOCK freezes the choice: OBI forbids a manager retracting req before gnt.
  always_comb begin
    state_next = state;
    idx        = state == LOCK ? lock_idx : sel;
    sbr_req_o  = '0;
    if (state == LOCK) sbr_req_o = mgr_req_i[lock_idx];
    else if (any_req && !full) begin
      sbr_req_o     = mgr_req_i[sel];
      sbr_req_o.req = 1'b1;
    end
    sbr_req_o.rready = 1'b0;
    if (rst_i) sbr_req_o = '0;
    accept = sbr_req_o.req && sbr_rsp_i.gnt;
    if (sbr_req_o.req) state_next = accept ? IDLE : LOCK;
  end
  assign pop = sbr_rsp_i.rvalid && count != '0 && !rst_i;
  always_comb
    for (int i = 0; i < NumMgr; i++) begin
      mgr_rsp_o[i]        = '0;
      mgr_rsp_o[i].gnt    = accept && idx == IdxW'(i);
      mgr_rsp_o[i].rvalid = pop && head == IdxW'(i);
      mgr_rsp_o[i].r      = pop && head == IdxW'(i) ? sbr_rsp_i.r : '0;
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < MaxTrans; i++) fifo[i] <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) lock_idx <= sel;
      if (accept) begin
        fifo[wr_ptr] <= idx;
        wr_ptr       <= next_slot(wr_ptr);
        ptr          <= idx == IdxW'(NumMgr - 1) ? '0 : idx + 1'b1;
      end
      if (pop) rd_ptr <= next_slot(rd_ptr);
      count <= count + CntW'(accept) - CntW'(pop);
    end
`ifdef OBI_RR_ARBITER_UNEXP_RSP_EN
  logic unexp_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) unexp_q <= 1'b0;
    else if (sbr_rsp_i.rvalid && count == '0) unexp_q <= 1'b1;
  assign unexp_rsp_o = unexp_q;
  always @(posedge clk_i)
    if (!rst_i) assert (!(sbr_rsp_i.rvalid && count == '0))
      else $warning("obi_rr_arbiter: rvalid with no outstanding transaction");
`else
  assign unexp_rsp_o = 1'b0;
`endif
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed vectors for obi_rr_arbiter (NumMgr=2, MaxTrans=2).
module tb_obi_rr_arbiter;
  import obi_rr_arbiter_pkg::*;
`ifdef OBI_RR_ARBITER_UNEXP_RSP_EN
  localparam logic ExpUnexp = 1'b1;
`else
  localparam logic ExpUnexp = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  sbr_obi_req_t mreq [2];
  sbr_obi_rsp_t mrsp [2];
  sbr_obi_req_t sreq;
  sbr_obi_rsp_t srsp;
  logic busy, unexp;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  obi_rr_arbiter #(.NumMgr(2), .MaxTrans(2)) dut (
    .clk_i(clk), .rst_i(rst), .mgr_req_i(mreq), .mgr_rsp_o(mrsp),
    .sbr_req_o(sreq), .sbr_rsp_i(srsp), .busy_o(busy), .unexp_rsp_o(unexp)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_req(input int m, input logic r, input logic [31:0] a);
    mreq[m].req    = r;
    mreq[m].a.addr = a;
  endtask
  task automatic set_rsp(input logic g, input logic v, input logic [31:0] d, input logic e);
    srsp.gnt     = g;
    srsp.rvalid  = v;
    srsp.r.rdata = d;
    srsp.r.err   = e;
  endtask
  initial begin
    rst     = 1'b1;
    mreq[0] = '0;
    mreq[1] = '0;
    srsp    = '0;
    set_req(0, 1, 32'h100);
    set_req(1, 1, 32'h200);
    set_rsp(1, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_sreq", sreq, 0);
    check("rst_mrsp0", mrsp[0], 0);
    check("rst_mrsp1", mrsp[1], 0);
    check("rst_busy", busy, 0);
    check("rst_unexp", unexp, 0);
    rst = 1'b0;
    // both managers request every cycle, response one cycle after each grant
    for (int k = 0; k < 8; k++) begin
      set_rsp(1, k > 0, 32'hA000 + k - 1, 0);
      #1;
      check("alt_gnt0", mrsp[0].gnt, k % 2 == 0);
      check("alt_gnt1", mrsp[1].gnt, k % 2 == 1);
      check("alt_addr", sreq.a.addr, k % 2 ? 32'h200 : 32'h100);
      if (k > 0) begin
        check("alt_rv", mrsp[(k - 1) % 2].rvalid, 1);
        check("alt_rdata", mrsp[(k - 1) % 2].r.rdata, 32'hA000 + k - 1);
        check("alt_rv_other", mrsp[k % 2].rvalid, 0);
      end
      @(negedge clk);
    end
    set_req(0, 0, 0);
    set_req(1, 0, 0);
    set_rsp(0, 1, 32'hA007, 0);
    #1;
    check("alt_last_rv", mrsp[1].rvalid, 1);
    check("alt_last_rdata", mrsp[1].r.rdata, 32'hA007);
    check("alt_idle_req", sreq.req, 0);
    @(negedge clk);
    set_rsp(0, 0, 0, 0);
    #1;
    check("alt_busy", busy, 0);
    // FIFO full: two accepts then stall until a response frees a slot
    set_req(0, 1, 32'h300);
    set_rsp(1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("full_acc", mrsp[0].gnt, 1);
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      check("full_req", sreq.req, 0);
      check("full_gnt", mrsp[0].gnt, 0);
      check("full_busy", busy, 1);
      @(negedge clk);
    end
    set_rsp(1, 1, 32'hDEADBEEF, 0);
    #1;
    check("full_rv", mrsp[0].rvalid, 1);
    check("full_rdata", mrsp[0].r.rdata, 32'hDEADBEEF);
    check("full_req_pop", sreq.req, 0);
    @(negedge clk);
    set_rsp(1, 0, 0, 0);
    #1;
    check("full_reacc", mrsp[0].gnt, 1);
    @(negedge clk);
    set_req(0, 0, 0);
    set_rsp(0, 1, 0, 0);
    repeat (2) @(negedge clk);
    set_rsp(0, 0, 0, 0);
    #1;
    check("full_drain", busy, 0);
    // gnt withheld: manager 1 locked in although manager 0 joins
    set_req(1, 1, 32'h1000_0010);
    #1;
    check("lock_addr", sreq.a.addr, 32'h1000_0010);
    check("lock_req", sreq.req, 1);
    check("lock_gnt1", mrsp[1].gnt, 0);
    @(negedge clk);
    set_req(0, 1, 32'h400);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("lock_hold", sreq.a.addr, 32'h1000_0010);
      check("lock_gnt0", mrsp[0].gnt, 0);
      @(negedge clk);
    end
    set_rsp(1, 0, 0, 0);
    #1;
    check("lock_acc1", mrsp[1].gnt, 1);
    check("lock_acc0", mrsp[0].gnt, 0);
    @(negedge clk);
    set_req(1, 1, 32'h500);
    #1;
    check("lock_next0", mrsp[0].gnt, 1);
    check("lock_next1", mrsp[1].gnt, 0);
    check("lock_next_addr", sreq.a.addr, 32'h400);
    @(negedge clk);
    // in-order routing: manager 1 was issued first
    set_req(0, 0, 0);
    set_req(1, 0, 0);
    set_rsp(0, 1, 32'h0000_00A5, 0);
    #1;
    check("route_rv1", mrsp[1].rvalid, 1);
    check("route_rdata1", mrsp[1].r.rdata, 32'hA5);
    check("route_err1", mrsp[1].r.err, 0);
    check("route_rv0_off", mrsp[0].rvalid, 0);
    @(negedge clk);
    set_rsp(0, 1, 0, 1);
    #1;
    check("route_rv0", mrsp[0].rvalid, 1);
    check("route_err0", mrsp[0].r.err, 1);
    check("route_rv1_off", mrsp[1].rvalid, 0);
    check("route_r1_zero", mrsp[1].r, 0);
    @(negedge clk);
    set_rsp(0, 0, 0, 0);
    #1;
    check("route_busy", busy, 0);
    // reset with two outstanding, then a late response
    set_req(0, 1, 32'h600);
    set_req(1, 1, 32'h700);
    set_rsp(1, 0, 0, 0);
    #1;
    check("mid_gnt1", mrsp[1].gnt, 1);
    @(negedge clk);
    #1;
    check("mid_gnt0", mrsp[0].gnt, 1);
    @(negedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_sreq", sreq, 0);
    check("mid_rst_mrsp0", mrsp[0], 0);
    check("mid_rst_mrsp1", mrsp[1], 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 0, 0);
    set_req(1, 0, 0);
    set_rsp(0, 1, 32'hBAD, 0);
    #1;
    check("late_rv0", mrsp[0].rvalid, 0);
    check("late_rv1", mrsp[1].rvalid, 0);
    @(negedge clk);
    set_req(0, 1, 32'h800);
    set_req(1, 1, 32'h900);
    set_rsp(1, 0, 0, 0);
    #1;
    check("unexp_flag", unexp, ExpUnexp);
    check("post_rst_gnt0", mrsp[0].gnt, 1);
    check("post_rst_gnt1", mrsp[1].gnt, 0);
    @(negedge clk);
    #1;
    check("unexp_sticky", unexp, ExpUnexp);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI subordinate port (sbr_obi_req_t / sbr_obi_rsp_t) between NumMgr manager ports using round-robin arbitration.
- Instantiated upstream of a peripheral (e.g. Foo or Bar) when more than one manager must reach it.
- Tracks outstanding transactions in an in-order ID FIFO so each R-channel response returns to the manager that issued it.
- Purely sequencing and routing; the A- and R-channel payloads pass through unmodified.

Parameters:
- NumMgr, 2, number of manager ports (2..8).
- MaxTrans, 2, maximum outstanding (granted, not yet responded) transactions (1..8); sets the ID FIFO depth.
- IdxW, $clog2(NumMgr) (min 1), derived width of a manager index; not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- mgr_req_i  in  NumMgr x sbr_obi_req_t  manager requests (A channel + req)
- mgr_rsp_o  out  NumMgr x sbr_obi_rsp_t  manager responses (gnt, rvalid, R channel)
- sbr_req_o  out  sbr_obi_req_t  request to subordinate
- sbr_rsp_i  in  sbr_obi_rsp_t  response from subordinate
- busy_o  out  1  high while at least one transaction is outstanding
- unexp_rsp_o  out  1  sticky: rvalid arrived with no transaction outstanding (see Optional Feature)

Behaviour:
- Reset (async, rst_i=1):
  - FIFO empty; round-robin pointer = 0; arbiter state IDLE.
  - All outputs 0: sbr_req_o='0, every mgr_rsp_o='0, busy_o=0, unexp_rsp_o=0.
- Arbiter FSM, state IDLE:
  - sel = first requesting manager at or after pointer, cyclic scan.
  - If any req is high and FIFO not full: drive sbr_req_o = mgr_req_i[sel] (req=1).
  - If sbr gnt=1 the same cycle: accept, stay IDLE. Otherwise latch sel and go to LOCK.
- State LOCK:
  - Forward only the latched manager. OBI forbids retracting req or changing the A channel before gnt, so the arbitration decision is frozen.
  - On gnt: accept, return to IDLE.
- Accept (sbr req && gnt):
  - Assert mgr_rsp_o[sel].gnt combinationally (same cycle). All other gnt are 0.
  - Push sel into the FIFO.
  - Pointer <= (sel+1) mod NumMgr.
- FIFO full (MaxTrans outstanding) in IDLE:
  - sbr_req_o.req = 0; no manager sees gnt.
  - Requests wait; the pointer does not move.
- Response routing:
  - sbr_rsp_i.rvalid with FIFO non-empty: mgr_rsp_o[head].rvalid=1, and its r fields = sbr_rsp_i.r. Pop the head.
  - Non-head managers: rvalid=0, r='0.
  - No rready handshake (UseRReady=0); mgr rready is ignored and the rready fields are driven 0.
- Simultaneous accept and response in one cycle: push and pop both occur; count unchanged. This is legal when full (pop frees a slot only for the next cycle; the full check uses the registered count).
- Earliest response: the cycle after its gnt. A combinational gnt→rvalid path is not supported.
- busy_o = (count != 0), registered with the count.
- Single requester: it is granted every eligible cycle; back-to-back accepts are allowed while FIFO not full.
- Reset mid-transaction: FIFO cleared. Late rvalids after reset count as unexpected responses and are not routed.

Optional Feature:
- Macro: OBI_RR_ARBITER_UNEXP_RSP_EN.
- Defined:
  - rvalid with FIFO empty sets unexp_rsp_o; it stays 1 until reset.
  - The response is dropped: no manager sees rvalid.
  - A simulation assertion fires as well.
- Undefined:
  - unexp_rsp_o is tied 0; no check logic.
  - An rvalid with FIFO empty is dropped silently.

Test Plan:
- Managers 0 and 1 both request continuously; subordinate gnt=1 always, rvalid one cycle after each gnt → grants alternate 0,1,0,1; each rdata returns to its issuer; 8 transactions in 8 cycles.
- MaxTrans=2; subordinate holds rvalid=0 → two accepts, then sbr req=0 and busy_o=1. rvalid on cycle 5 → head manager gets rdata 0xDEAD_BEEF, next request accepted cycle 6.
- Manager 1 requests addr 0x1000_0010; gnt withheld 3 cycles; manager 0 asserts req meanwhile → sbr_req_o stays manager 1's addr until gnt; manager 0 granted next.
- Responses with err=1 for manager 0 and rdata 0x0000_00A5 for manager 1, in issue order → the err flag and data reach the correct managers.
- Assert rst_i while 2 transactions are outstanding → all outputs 0 asynchronously. Next grant goes to manager 0.
- Macro defined; inject rvalid with FIFO empty → unexp_rsp_o=1, sticky; no mgr rvalid. Macro undefined, same stimulus → unexp_rsp_o=0.
